// File: rtl/l1_snoop_responder.sv
// Snoop agent for one private L1: answers MESI bus snoops through a dedicated tag-array port
// and writes back the downgraded/invalidated line state. Optional macro: SHARED_SUPPLY_EN.
module l1_snoop_responder #(
  parameter int BLOCK_SIZE = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     ccwait,
  input  logic                     ccinv,
  input  logic [31:0]              ccsnoopaddr,
  output logic                     ccsnoopdone,
  output logic                     ccsnoophit,
  output logic                     ccIsPresent,
  output logic                     ccdirty,
  output logic [BLOCK_SIZE*32-1:0] dstore,
  output logic                     tag_req,
  output logic [31:0]              tag_addr,
  input  logic [1:0]               tag_rstate,
  input  logic [BLOCK_SIZE*32-1:0] tag_rdata,
  output logic                     tag_wen,
  output logic [31:0]              tag_waddr,
  output logic [1:0]               tag_wstate,
  output logic                     snoop_busy
);

  localparam int DATA_W = BLOCK_SIZE * 32;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    RESPOND = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       addr_p0;
  logic              inv_p0;
  logic              present_p1;
  logic              dirty_p1;
  logic              hit_p1;
  logic [DATA_W-1:0] data_p1;

  function automatic logic supplies(input logic [1:0] st);
`ifdef SHARED_SUPPLY_EN
    return (st == MESI_M) || (st == MESI_E) || (st == MESI_S);
`else
    return (st == MESI_M) || (st == MESI_E);
`endif
  endfunction

  // A remote read leaves us sharing; any invalidate seen in the window kills the line.
  function automatic logic [1:0] next_mesi(input logic inv);
    return inv ? MESI_I : MESI_S;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: snoop address and invalidate qualifier; stage p1: registered lookup result.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_p0    <= '0;
      inv_p0     <= 1'b0;
      present_p1 <= 1'b0;
      dirty_p1   <= 1'b0;
      hit_p1     <= 1'b0;
      data_p1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ccwait) begin
            addr_p0 <= ccsnoopaddr;
            inv_p0  <= ccinv;
          end
        end
        LOOKUP: begin
          present_p1 <= (tag_rstate != MESI_I);
          dirty_p1   <= (tag_rstate == MESI_M);
          hit_p1     <= supplies(tag_rstate);
          data_p1    <= tag_rdata;
          inv_p0     <= inv_p0 | ccinv;
        end
        RESPOND: inv_p0 <= inv_p0 | ccinv;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    tag_req     = 1'b0;
    tag_addr    = '0;
    tag_wen     = 1'b0;
    tag_waddr   = '0;
    tag_wstate  = MESI_I;
    ccsnoophit  = 1'b0;
    ccIsPresent = 1'b0;
    ccdirty     = 1'b0;
    dstore      = '0;
    ccsnoopdone = !ccwait || (state == RESPOND);
    snoop_busy  = ccwait || (state != IDLE);
    case (state)
      IDLE: begin
        // Request is suppressed while reset is held so the array sees no stray lookup.
        if (ccwait && nRST) begin
          tag_req   = 1'b1;
          tag_addr  = ccsnoopaddr;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: state_nxt = RESPOND;
      RESPOND: begin
        ccsnoophit  = hit_p1;
        ccIsPresent = present_p1;
        ccdirty     = dirty_p1;
        dstore      = data_p1;
        if (!ccwait) state_nxt = UPDATE;
      end
      UPDATE: begin
        if (present_p1) begin
          tag_wen    = 1'b1;
          tag_waddr  = addr_p0;
          tag_wstate = next_mesi(inv_p0);
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Self-checking bench for l1_snoop_responder: directed vector table, reset/corner sequences,
// and randomized snoops checked against a transaction-level MESI model.
module tb_l1_snoop_responder;

  localparam int BS = 2;
  localparam int DW = BS * 32;

`ifdef SHARED_SUPPLY_EN
  localparam bit S_HIT = 1'b1;
`else
  localparam bit S_HIT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ccwait, ccinv;
  logic [31:0]   ccsnoopaddr;
  logic          ccsnoopdone, ccsnoophit, ccIsPresent, ccdirty;
  logic [DW-1:0] dstore;
  logic          tag_req;
  logic [31:0]   tag_addr;
  logic [1:0]    tag_rstate;
  logic [DW-1:0] tag_rdata;
  logic          tag_wen;
  logic [31:0]   tag_waddr;
  logic [1:0]    tag_wstate;
  logic          snoop_busy;

  always #5 CLK = ~CLK;

  l1_snoop_responder #(.BLOCK_SIZE(BS)) dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ccsnoopdone(ccsnoopdone), .ccsnoophit(ccsnoophit), .ccIsPresent(ccIsPresent),
    .ccdirty(ccdirty), .dstore(dstore), .tag_req(tag_req), .tag_addr(tag_addr),
    .tag_rstate(tag_rstate), .tag_rdata(tag_rdata), .tag_wen(tag_wen),
    .tag_waddr(tag_waddr), .tag_wstate(tag_wstate), .snoop_busy(snoop_busy)
  );

  // Tag array stand-in: one-cycle read; returns the inverse when not requested so a
  // mistimed sample shows up as wrong data.
  logic [1:0]    cur_state = 2'b00;
  logic [DW-1:0] cur_data  = '0;
  always @(posedge CLK) begin
    if (tag_req) begin
      tag_rstate <= cur_state;
      tag_rdata  <= cur_data;
    end else begin
      tag_rstate <= ~cur_state;
      tag_rdata  <= ~cur_data;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  st;
    logic [63:0] data;
    int          len;   // cycles ccwait is high
    logic [15:0] inv;   // ccinv per ccwait cycle
    bit          ovl;   // raise next ccwait during the update cycle
    bit          hit, pres, dirty, wen;
    logic [1:0]  wst;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string ph, input logic e_req, input logic [31:0] e_taddr,
                         input logic e_done, input logic e_hit, input logic e_pres,
                         input logic e_dirty, input logic [63:0] e_ds, input logic e_wen,
                         input logic [31:0] e_waddr, input logic [1:0] e_wst, input logic e_busy);
    chk({ph, ".tag_req"},     tag_req,     e_req);
    chk({ph, ".tag_addr"},    tag_addr,    e_taddr);
    chk({ph, ".ccsnoopdone"}, ccsnoopdone, e_done);
    chk({ph, ".ccsnoophit"},  ccsnoophit,  e_hit);
    chk({ph, ".ccIsPresent"}, ccIsPresent, e_pres);
    chk({ph, ".ccdirty"},     ccdirty,     e_dirty);
    chk({ph, ".dstore"},      dstore,      e_ds);
    chk({ph, ".tag_wen"},     tag_wen,     e_wen);
    chk({ph, ".tag_waddr"},   tag_waddr,   e_waddr);
    chk({ph, ".tag_wstate"},  tag_wstate,  e_wst);
    chk({ph, ".snoop_busy"},  snoop_busy,  e_busy);
  endtask

  // Reference: MESI response rules applied to a whole transaction.
  function automatic vec_t model(input logic [31:0] a, input logic [1:0] st,
                                 input logic [63:0] d, input int len,
                                 input logic [15:0] inv, input bit ovl);
    vec_t v;
    logic [15:0] window;
    v.addr = a; v.st = st; v.data = d; v.len = len; v.inv = inv; v.ovl = ovl;
    v.pres  = (st != 2'b00);
    v.dirty = (st == 2'b11);
    v.hit   = (st == 2'b11) || (st == 2'b10) || (S_HIT && st == 2'b01);
    v.wen   = v.pres;
    window  = (16'h1 << len) - 16'h1;
    v.wst   = ((inv & window) != 16'h0) ? 2'b00 : 2'b01;
    return v;
  endfunction

  // Drives one snoop from a negedge and checks every cycle of its timeline.
  task automatic run_snoop(input vec_t v);
    int last;
    last = (v.len < 2) ? 2 : v.len;
    ccsnoopaddr = v.addr; cur_state = v.st; cur_data = v.data;
    ccwait = 1'b1; ccinv = v.inv[0];
    #1 chk_all("launch", 1, v.addr, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    for (int c = 1; c <= last; c++) begin
      ccwait = (c < v.len);
      ccinv  = (c < v.len) ? v.inv[c] : 1'b0;
      #1;
      if (c == 1) chk_all("lookup", 0, 0, !ccwait, 0, 0, 0, 0, 0, 0, 0, 1);
      else chk_all("respond", 0, 0, 1, v.hit, v.pres, v.dirty, v.data, 0, 0, 0, 1);
      @(negedge CLK);
    end
    ccwait = v.ovl; ccinv = 1'b0;
    #1 chk_all("update", 0, 0, !v.ovl, 0, 0, 0, 0, v.wen,
               v.wen ? v.addr : 32'h0, v.wen ? v.wst : 2'b00, 1);
    @(negedge CLK);
    if (!v.ovl) begin
      #1 chk_all("idle", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
    end
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h0000_0100, 2'b00, 64'h1111_2222_3333_4444, 4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{32'h0000_0200, 2'b11, 64'hDEADBEEF_CAFEF00D, 3, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
    tbl[2] = '{32'h0000_1040, 2'b10, 64'h0123_4567_89AB_CDEF, 3, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[3] = '{32'h0000_1080, 2'b01, 64'hA5A5_5A5A_0F0F_F0F0, 2, 16'h0003, 1'b0, S_HIT, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[4] = '{32'h0000_10C0, 2'b01, 64'h0000_0000_FFFF_FFFF, 5, 16'h0000, 1'b0, S_HIT, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[5] = '{32'h0000_2000, 2'b11, 64'h8000_0000_0000_0001, 4, 16'h0008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
    tbl[6] = '{32'h0000_3000, 2'b10, 64'h1234_5678_9ABC_DEF0, 1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[7] = '{32'h0000_4000, 2'b10, 64'hCAFE_BABE_F00D_FACE, 3, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[8] = '{32'h0000_4040, 2'b00, 64'hFFFF_0000_FFFF_0000, 2, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = 32'h0;
    #2 chk_all("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    ccwait = 1'b1; ccsnoopaddr = 32'h0000_0500;
    #1 chk_all("reset_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    ccwait = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    #1 chk_all("post_reset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);

    for (int i = 0; i < 9; i++) run_snoop(tbl[i]);

    // Reset while responding: abandoned, no write afterwards.
    ccsnoopaddr = 32'h0000_6000; cur_state = 2'b11; cur_data = 64'hFEED_FACE_DEAD_BEEF;
    ccwait = 1'b1; ccinv = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1 chk("rst_seq.respond_hit", ccsnoophit, 1'b1);
    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0;
    #1 chk_all("rst_mid", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_all("rst_after", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
    end
    run_snoop(tbl[1]);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [15:0] inv;
      int          len;
      bit          ovl;
      a   = $urandom & 32'hFFFF_FFF8;
      len = $urandom_range(1, 8);
      inv = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
      ovl = (i != 39) && ($urandom_range(0, 3) == 0);
      run_snoop(model(a, 2'($urandom_range(0, 3)), {$urandom, $urandom}, len, inv, ovl));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
